// File: rtl/sopc_mem_bridge_pkg.sv
// Shared types for the CPU-to-memory bridge: FSM state codes, grant codes,
// default widths/timeout and the fetch/data arbitration rule.
package sopc_mem_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      GNT_INST = 1'b0,
      GNT_DATA = 1'b1
   } grant_t;

   localparam int DEFAULT_ADDR_W  = 32;
   localparam int DEFAULT_DATA_W  = 32;
   localparam int DEFAULT_TIMEOUT = 16;

   // Data normally wins, but never twice in a row while a fetch is waiting.
   function automatic grant_t pick_grant(input logic   inst_req,
                                         input logic   data_req,
                                         input grant_t last);
      if (data_req && (!inst_req || last != GNT_DATA))
         return GNT_DATA;
      return GNT_INST;
   endfunction

endpackage

// File: rtl/sopc_mem_bridge.sv
// Merges the CPU fetch and data ports onto one req/ack memory port with
// alternating-priority arbitration, pipeline stall request and access timeout.
module sopc_mem_bridge
   import sopc_mem_bridge_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int SEL_W   = DATA_W / 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int TO_W    = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_ce_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   output logic [DATA_W-1:0] inst_data_o,
   output logic              inst_ack_o,
   input  logic              data_ce_i,
   input  logic              data_we_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [SEL_W-1:0]  data_sel_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic [DATA_W-1:0] data_rdata_o,
   output logic              data_ack_o,
   output logic              bus_err_o,
   output logic              stall_req_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [SEL_W-1:0]  mem_sel_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   grant_t            grant, grant_nxt;
   grant_t            last_grant, last_grant_nxt;
   logic [TO_W-1:0]   cnt, cnt_nxt;

   logic              req_nxt, we_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [SEL_W-1:0]  sel_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic              inst_ack_nxt, data_ack_nxt, bus_err_nxt;
   logic [DATA_W-1:0] inst_data_nxt, data_rdata_nxt;

   logic              timed_out;
   logic [DATA_W-1:0] resp_data;

   assign timed_out   = (TIMEOUT != 0) && (cnt == TO_LAST);
   assign resp_data   = mem_we_o ? '0 : mem_rdata_i;
   assign stall_req_o = (inst_ce_i & ~inst_ack_o) | (data_ce_i & ~data_ack_o);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      cnt_nxt        = cnt;
      req_nxt        = mem_req_o;
      we_nxt         = mem_we_o;
      addr_nxt       = mem_addr_o;
      sel_nxt        = mem_sel_o;
      wdata_nxt      = mem_wdata_o;
      inst_data_nxt  = inst_data_o;
      data_rdata_nxt = data_rdata_o;
      inst_ack_nxt   = 1'b0;
      data_ack_nxt   = 1'b0;
      bus_err_nxt    = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (inst_ce_i || data_ce_i) begin
               grant_nxt      = pick_grant(inst_ce_i, data_ce_i, last_grant);
               last_grant_nxt = grant_nxt;
               req_nxt        = 1'b1;
               cnt_nxt        = '0;
               state_nxt      = ST_WAIT;
               if (grant_nxt == GNT_DATA) begin
                  we_nxt    = data_we_i;
                  addr_nxt  = data_addr_i;
                  sel_nxt   = data_sel_i;
                  wdata_nxt = data_wdata_i;
               end else begin
                  we_nxt    = 1'b0;
                  addr_nxt  = inst_addr_i;
                  sel_nxt   = '1;
                  wdata_nxt = '0;
               end
            end
         end
         ST_WAIT: begin
            // A late ack in the timeout cycle still counts as a clean completion.
            if (mem_ack_i || timed_out) begin
               req_nxt     = 1'b0;
               bus_err_nxt = ~mem_ack_i;
               state_nxt   = ST_RESP;
               if (grant == GNT_DATA) begin
                  data_ack_nxt   = 1'b1;
                  data_rdata_nxt = mem_ack_i ? resp_data : '0;
               end else begin
                  inst_ack_nxt  = 1'b1;
                  inst_data_nxt = mem_ack_i ? resp_data : '0;
               end
            end else begin
               cnt_nxt = cnt + TO_W'(1);
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      if (rst) begin
         state        <= ST_IDLE;
         grant        <= GNT_INST;
         last_grant   <= GNT_INST;
         cnt          <= '0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_sel_o    <= '0;
         mem_wdata_o  <= '0;
         inst_data_o  <= '0;
         data_rdata_o <= '0;
         inst_ack_o   <= 1'b0;
         data_ack_o   <= 1'b0;
         bus_err_o    <= 1'b0;
      end else begin
         state        <= state_nxt;
         grant        <= grant_nxt;
         last_grant   <= last_grant_nxt;
         cnt          <= cnt_nxt;
         mem_req_o    <= req_nxt;
         mem_we_o     <= we_nxt;
         mem_addr_o   <= addr_nxt;
         mem_sel_o    <= sel_nxt;
         mem_wdata_o  <= wdata_nxt;
         inst_data_o  <= inst_data_nxt;
         data_rdata_o <= data_rdata_nxt;
         inst_ack_o   <= inst_ack_nxt;
         data_ack_o   <= data_ack_nxt;
         bus_err_o    <= bus_err_nxt;
      end
   end

endmodule

// File: tb/tb_sopc_mem_bridge.sv
// Randomized and directed bench for sopc_mem_bridge against an access-level
// model, plus literal checks of the documented latency/timeout/arbitration cases.
module tb_sopc_mem_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          inst_ce_i = 1'b0, data_ce_i = 1'b0, data_we_i = 1'b0;
   logic [AW-1:0] inst_addr_i = '0, data_addr_i = '0;
   logic [SW-1:0] data_sel_i = '0;
   logic [DW-1:0] data_wdata_i = '0, mem_rdata_i = '0;
   logic          mem_ack_i = 1'b0;

   logic [DW-1:0] inst_data_o, data_rdata_o, mem_wdata_o;
   logic          inst_ack_o, data_ack_o, bus_err_o, stall_req_o, mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [SW-1:0] mem_sel_o;

   logic [DW-1:0] inst_data0, data_rdata0, mem_wdata0;
   logic          inst_ack0, data_ack0, bus_err0, stall0, mem_req0, mem_we0;
   logic [AW-1:0] mem_addr0;
   logic [SW-1:0] mem_sel0;

   always #5 clk = ~clk;

   sopc_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(5)) dut (
      .clk(clk), .rst(rst),
      .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o), .inst_ack_o(inst_ack_o),
      .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i), .data_sel_i(data_sel_i),
      .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_ack_o(data_ack_o),
      .bus_err_o(bus_err_o), .stall_req_o(stall_req_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i));

   sopc_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0), .TO_W(5)) dut0 (
      .clk(clk), .rst(rst),
      .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data0), .inst_ack_o(inst_ack0),
      .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i), .data_sel_i(data_sel_i),
      .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata0), .data_ack_o(data_ack0),
      .bus_err_o(bus_err0), .stall_req_o(stall0),
      .mem_req_o(mem_req0), .mem_we_o(mem_we0), .mem_addr_o(mem_addr0), .mem_sel_o(mem_sel0),
      .mem_wdata_o(mem_wdata0), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- access-level reference model (TIMEOUT=16 instance) ----------------
   logic          e_req = 0, e_we = 0, e_inst_ack = 0, e_data_ack = 0, e_err = 0;
   logic [AW-1:0] e_addr = '0;
   logic [SW-1:0] e_sel = '0;
   logic [DW-1:0] e_wdata = '0, e_inst_data = '0, e_data_rdata = '0;
   bit            m_active = 0, m_resp = 0, m_data = 0, m_last_data = 0;
   int            m_waited = 0;

   always @(posedge clk) begin
      logic [DW-1:0] rd;
      e_inst_ack = 0;
      e_data_ack = 0;
      e_err      = 0;
      if (rst) begin
         e_req = 0; e_we = 0; e_addr = '0; e_sel = '0; e_wdata = '0;
         e_inst_data = '0; e_data_rdata = '0;
         m_active = 0; m_resp = 0; m_last_data = 0;
      end else if (m_resp) begin
         m_resp = 0;
      end else if (m_active) begin
         m_waited++;
         if (mem_ack_i || m_waited == TO) begin
            rd = (mem_ack_i && !e_we) ? mem_rdata_i : '0;
            if (m_data) begin e_data_ack = 1; e_data_rdata = rd; end
            else        begin e_inst_ack = 1; e_inst_data  = rd; end
            e_err = !mem_ack_i;
            e_req = 0;
            m_active = 0;
            m_resp = 1;
         end
      end else if (inst_ce_i || data_ce_i) begin
         m_data      = data_ce_i && !(inst_ce_i && m_last_data);
         m_last_data = m_data;
         m_active    = 1;
         m_waited    = 0;
         e_req       = 1;
         if (m_data) begin
            e_we = data_we_i; e_addr = data_addr_i; e_sel = data_sel_i; e_wdata = data_wdata_i;
         end else begin
            e_we = 0; e_addr = inst_addr_i; e_sel = '1; e_wdata = '0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      check("mem_req",    mem_req_o,    e_req);
      check("mem_we",     mem_we_o,     e_we);
      check("mem_addr",   mem_addr_o,   e_addr);
      check("mem_sel",    mem_sel_o,    e_sel);
      check("mem_wdata",  mem_wdata_o,  e_wdata);
      check("inst_ack",   inst_ack_o,   e_inst_ack);
      check("data_ack",   data_ack_o,   e_data_ack);
      check("bus_err",    bus_err_o,    e_err);
      check("inst_data",  inst_data_o,  e_inst_data);
      check("data_rdata", data_rdata_o, e_data_rdata);
      check("stall_req",  stall_req_o,
            (inst_ce_i & ~e_inst_ack) | (data_ce_i & ~e_data_ack));
   end

   // ---------------- memory responder and random requestors ----------------
   bit            rand_on = 0;
   bit            use_dut0 = 0;
   int            fixed_delay = 0;
   logic [DW-1:0] fixed_rdata = '0;
   int            wait_left = -1;

   always @(negedge clk) begin
      logic req;
      req = use_dut0 ? mem_req0 : mem_req_o;
      mem_rdata_i = $urandom;
      if (req) begin
         if (wait_left < 0)
            wait_left = rand_on ? (($urandom_range(7) == 0) ? 20 : int'($urandom_range(3))) : fixed_delay;
         if (wait_left == 0) begin
            mem_ack_i = 1'b1;
            if (!rand_on) mem_rdata_i = fixed_rdata;
            wait_left = -1;
         end else begin
            mem_ack_i = 1'b0;
            wait_left--;
         end
      end else begin
         mem_ack_i = rand_on && ($urandom_range(5) == 0);
         wait_left = -1;
      end
   end

   always @(negedge clk) begin
      if (rand_on) begin
         if (!inst_ce_i) begin
            if ($urandom_range(2) == 0) begin inst_ce_i = 1'b1; inst_addr_i = $urandom; end
         end else if (inst_ack_o) begin
            inst_ce_i = 1'($urandom_range(1)); inst_addr_i = $urandom;
         end else if ($urandom_range(49) == 0) begin
            inst_ce_i = 1'b0;
         end
         if (!data_ce_i) begin
            if ($urandom_range(2) == 0) begin
               data_ce_i = 1'b1; data_we_i = 1'($urandom_range(1)); data_addr_i = $urandom;
               data_sel_i = 4'($urandom); data_wdata_i = $urandom;
            end
         end else if (data_ack_o) begin
            data_ce_i = 1'($urandom_range(1)); data_we_i = 1'($urandom_range(1));
            data_addr_i = $urandom; data_sel_i = 4'($urandom); data_wdata_i = $urandom;
         end else if ($urandom_range(49) == 0) begin
            data_ce_i = 1'b0;
         end
      end
   end

   // ---------------- directed single access ----------------
   int            r_req, r_lat;
   bit            r_err, r_stall_ok, r_done, r_we;
   logic [DW-1:0] r_data, r_wdata;
   logic [AW-1:0] r_addr;
   logic [SW-1:0] r_sel;

   task automatic do_access(input bit d, input bit we, input logic [AW-1:0] addr,
                            input logic [SW-1:0] sel, input logic [DW-1:0] wd,
                            input int delay, input logic [DW-1:0] rd);
      fixed_delay = delay;
      fixed_rdata = rd;
      @(negedge clk);
      if (d) begin
         data_ce_i = 1'b1; data_we_i = we; data_addr_i = addr; data_sel_i = sel; data_wdata_i = wd;
      end else begin
         inst_ce_i = 1'b1; inst_addr_i = addr;
      end
      #1;
      r_stall_ok = (stall_req_o === 1'b1);
      r_req = 0; r_lat = 0; r_done = 0; r_err = 0; r_data = 'x;
      for (int i = 1; i <= 300 && !r_done; i++) begin
         @(negedge clk);
         if (mem_req_o) begin
            if (r_req == 0) begin
               r_we = mem_we_o; r_addr = mem_addr_o; r_sel = mem_sel_o; r_wdata = mem_wdata_o;
            end
            r_req++;
         end
         if (d ? data_ack_o : inst_ack_o) begin
            r_done = 1; r_lat = i; r_err = bus_err_o;
            r_data = d ? data_rdata_o : inst_data_o;
            if (stall_req_o !== 1'b0) r_stall_ok = 0;
         end else if (stall_req_o !== 1'b1) begin
            r_stall_ok = 0;
         end
      end
      inst_ce_i = 1'b0;
      data_ce_i = 1'b0;
      check("access_completes", r_done, 1);
   endtask

   initial begin
      bit            ord[4];
      int            cyc[4];
      int            n;
      int            req0;
      bit            done0;

      repeat (2) @(negedge clk);
      check("rst_mem_req",   mem_req_o,   0);
      check("rst_mem_sel",   mem_sel_o,   0);
      check("rst_inst_ack",  inst_ack_o,  0);
      check("rst_data_ack",  data_ack_o,  0);
      check("rst_bus_err",   bus_err_o,   0);
      check("rst_inst_data", inst_data_o, 0);
      rst = 1'b0;

      rand_on = 1;
      repeat (3000) @(negedge clk);
      rand_on = 0;
      @(negedge clk);
      inst_ce_i = 1'b0; data_ce_i = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // Zero-wait fetch
      do_access(0, 0, 32'h0000_0010, 4'hf, '0, 0, 32'h3401_1100);
      check("fetch_latency",  r_lat,      2);
      check("fetch_req_cyc",  r_req,      1);
      check("fetch_data",     r_data,     32'h3401_1100);
      check("fetch_addr",     r_addr,     32'h0000_0010);
      check("fetch_sel",      r_sel,      4'hf);
      check("fetch_stall",    r_stall_ok, 1);
      check("fetch_err",      r_err,      0);

      // Write with 3 wait states
      do_access(1, 1, 32'h0000_0100, 4'b0011, 32'hDEAD_BEEF, 3, 32'h1234_5678);
      check("wr_req_cyc",  r_req,   4);
      check("wr_latency",  r_lat,   5);
      check("wr_we",       r_we,    1);
      check("wr_sel",      r_sel,   4'b0011);
      check("wr_addr",     r_addr,  32'h0000_0100);
      check("wr_wdata",    r_wdata, 32'hDEAD_BEEF);
      check("wr_rdata",    r_data,  0);
      check("wr_err",      r_err,   0);

      // Memory never answers
      do_access(1, 0, 32'h0000_0200, 4'hf, '0, 1000, 32'h0000_0055);
      check("to_req_cyc",  r_req,  16);
      check("to_latency",  r_lat,  17);
      check("to_err",      r_err,  1);
      check("to_rdata",    r_data, 0);

      // Ack lands in the last allowed wait cycle
      do_access(1, 0, 32'h0000_0204, 4'hf, '0, 15, 32'hCAFE_F00D);
      check("late_req_cyc", r_req,  16);
      check("late_err",     r_err,  0);
      check("late_rdata",   r_data, 32'hCAFE_F00D);

      // Reset in the second wait cycle of a read
      fixed_delay = 1000;
      @(negedge clk);
      data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0300; data_sel_i = 4'hf;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rr_mem_req",  mem_req_o,  0);
      check("rr_mem_addr", mem_addr_o, 0);
      check("rr_data_ack", data_ack_o, 0);
      check("rr_bus_err",  bus_err_o,  0);
      data_ce_i = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("rr_no_ack", data_ack_o | inst_ack_o, 0);
      do_access(0, 0, 32'h0000_0040, 4'hf, '0, 1, 32'h0BAD_C0DE);
      check("rr_fetch_req", r_req,  2);
      check("rr_fetch_lat", r_lat,  3);
      check("rr_fetch_dat", r_data, 32'h0BAD_C0DE);

      // Both requestors held: alternating grants
      fixed_delay = 0;
      @(negedge clk);
      inst_ce_i = 1'b1; inst_addr_i = 32'h0000_0080;
      data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0400; data_sel_i = 4'hf;
      n = 0;
      for (int i = 0; i < 60 && n < 4; i++) begin
         @(negedge clk);
         if (data_ack_o) begin ord[n] = 1; cyc[n] = i; n++; end
         else if (inst_ack_o) begin ord[n] = 0; cyc[n] = i; n++; end
      end
      inst_ce_i = 1'b0; data_ce_i = 1'b0;
      check("arb_count", n, 4);
      if (n == 4) begin
         check("arb_0_data", ord[0], 1);
         check("arb_1_inst", ord[1], 0);
         check("arb_2_data", ord[2], 1);
         check("arb_3_inst", ord[3], 0);
         for (int k = 1; k < 4; k++) check("arb_spacing", cyc[k] - cyc[k-1], 3);
      end

      // Timeout disabled: slow ack still completes cleanly
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      use_dut0 = 1;
      fixed_delay = 40;
      fixed_rdata = 32'h1357_9BDF;
      @(negedge clk);
      data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h0000_0500;
      data_sel_i = 4'hf; data_wdata_i = '0;
      req0 = 0; done0 = 0;
      for (int i = 0; i < 100 && !done0; i++) begin
         @(negedge clk);
         if (mem_req0) begin
            if (req0 == 0) begin
               check("nt_addr", mem_addr0, 32'h0000_0500);
               check("nt_sel",  mem_sel0,  4'hf);
               check("nt_we",   mem_we0,   0);
               check("nt_wd",   mem_wdata0, 0);
            end
            req0++;
         end
         if (data_ack0) begin
            done0 = 1;
            check("nt_err",   bus_err0,    0);
            check("nt_rdata", data_rdata0, 32'h1357_9BDF);
            check("nt_stall", stall0,      0);
            check("nt_iack",  inst_ack0,   0);
            check("nt_idata", inst_data0,  0);
         end
      end
      data_ce_i = 1'b0;
      use_dut0 = 0;
      check("nt_done",    done0, 1);
      check("nt_req_cyc", req0,  41);

      repeat (30) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
